cache_way_array: RTL

- Set-associative successor to the single-row tag/valid/dirty/data register group: NUM_SETS x NUM_WAYS lines held in flops.
- Adds per-set tag compare, byte-enabled partial writes, line fill, invalidate, tree-PLRU victim selection and a full-array flush sequencer.
- Sits between the L1 cache controller FSM and the line-fill/writeback unit.
- Registered response, 1-cycle latency.

---
 rtl/cache_way_array.sv | 384 ++++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/cache_way_array.sv
// -----------------------------------------------------------------------------
// cache_way_array
//
// Set-associative tag/valid/dirty/data line store (NUM_SETS x NUM_WAYS lines in
// flops) with per-set tag compare, byte-enabled partial writes, line fill,
// invalidate, tree-PLRU victim selection and a full-array flush sequencer.
// Sits between the L1 controller FSM and the line-fill/writeback unit.
// All responses are registered and appear exactly one cycle after acceptance;
// the array updates on the same edge, so back-to-back ops see prior results.
//
// Optional feature: define CACHE_WAY_ARRAY_PARITY_EN to store even parity per
// data byte and per tag, checked on the hit/target way of each request.
// Without it rsp_perr_o is tied to 0.
//
// Ports:
//   clk_i, rst_ni        clock, synchronous active-low reset
//   req_valid_i/ready_o  request handshake (ready low while flushing)
//   req_op_i             0=LOOKUP 1=WRITE 2=FILL 3=INVAL
//   req_set_i/tag_i/way_i/data_i/be_i/dirty_i   request fields
//   flush_i              start full invalidate (IDLE only)
//   flush_busy_o         flush walk (and done cycle) in progress
//   flush_done_o         one-cycle pulse at flush end
//   rsp_*                registered response: hit, way, old data/dirty,
//                        victim way/tag/dirty, parity error
// -----------------------------------------------------------------------------
module cache_way_array #(
    parameter int TAG_BITS   = 51,
    parameter int DATA_WIDTH = 1024,
    parameter int NUM_SETS   = 64,
    parameter int NUM_WAYS   = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic [1:0]                    req_op_i,
    input  logic [$clog2(NUM_SETS)-1:0]   req_set_i,
    input  logic [TAG_BITS-1:0]           req_tag_i,
    input  logic [$clog2(NUM_WAYS)-1:0]   req_way_i,
    input  logic [DATA_WIDTH-1:0]         req_data_i,
    input  logic [DATA_WIDTH/8-1:0]       req_be_i,
    input  logic                          req_dirty_i,
    input  logic                          flush_i,
    output logic                          flush_busy_o,
    output logic                          flush_done_o,
    output logic                          rsp_valid_o,
    output logic                          rsp_hit_o,
    output logic [$clog2(NUM_WAYS)-1:0]   rsp_way_o,
    output logic [DATA_WIDTH-1:0]         rsp_data_o,
    output logic                          rsp_dirty_o,
    output logic [$clog2(NUM_WAYS)-1:0]   rsp_victim_way_o,
    output logic [TAG_BITS-1:0]           rsp_victim_tag_o,
    output logic                          rsp_victim_dirty_o,
    output logic                          rsp_perr_o
);

    localparam int SET_W  = $clog2(NUM_SETS);
    localparam int WAY_W  = $clog2(NUM_WAYS);
    localparam int BE_W   = DATA_WIDTH / 8;
    localparam int PLRU_W = NUM_WAYS - 1;

    localparam logic [1:0] OP_LOOKUP = 2'd0;
    localparam logic [1:0] OP_WRITE  = 2'd1;
    localparam logic [1:0] OP_FILL   = 2'd2;
    localparam logic [1:0] OP_INVAL  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WALK = 2'd1,
        ST_DONE = 2'd2
    } flush_state_e;

    // PLRU tree is stored heap-style: node n (1-based) lives at bit n-1, its
    // children are 2n and 2n+1, leaves map to ways as node - NUM_WAYS.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] bits);
        int node;
        node = 1;
        for (int l = 0; l < WAY_W; l++) begin
            node = 2 * node + (bits[node-1] ? 1 : 0);
        end
        return WAY_W'(node - NUM_WAYS);
    endfunction

    // Point every node on the path to 'way' at the opposite subtree.
    function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                     input logic [WAY_W-1:0]  way);
        logic [PLRU_W-1:0] nxt;
        int                node;
        nxt  = bits;
        node = 1;
        for (int l = 0; l < WAY_W; l++) begin
            nxt[node-1] = ~way[WAY_W-1-l];
            node        = 2 * node + (way[WAY_W-1-l] ? 1 : 0);
        end
        return nxt;
    endfunction

`ifdef CACHE_WAY_ARRAY_PARITY_EN
    // Even parity per byte: stored bit makes each 9-bit group even.
    function automatic logic [BE_W-1:0] byte_parity(input logic [DATA_WIDTH-1:0] line);
        logic [BE_W-1:0] p;
        for (int b = 0; b < BE_W; b++) begin
            p[b] = ^line[b*8 +: 8];
        end
        return p;
    endfunction

    function automatic logic tag_parity(input logic [TAG_BITS-1:0] tag);
        return ^tag;
    endfunction
`endif

    // ---------------------------------------------------------------- state
    flush_state_e          state_r;
    logic [SET_W-1:0]      flush_set_r;
    logic                  ready_r;
    logic                  busy_r;
    logic                  done_r;

    logic [NUM_WAYS-1:0]   valid_r [NUM_SETS];
    logic [NUM_WAYS-1:0]   dirty_r [NUM_SETS];
    logic [PLRU_W-1:0]     plru_r  [NUM_SETS];
    logic [TAG_BITS-1:0]   tag_r   [NUM_SETS][NUM_WAYS];
    logic [DATA_WIDTH-1:0] data_r  [NUM_SETS][NUM_WAYS];
`ifdef CACHE_WAY_ARRAY_PARITY_EN
    logic [BE_W-1:0]       dpar_r  [NUM_SETS][NUM_WAYS];
    logic                  tpar_r  [NUM_SETS][NUM_WAYS];
    logic [BE_W-1:0]       dpar_nxt_s;
`endif

    logic                  rsp_valid_r;
    logic                  rsp_hit_r;
    logic [WAY_W-1:0]      rsp_way_r;
    logic [DATA_WIDTH-1:0] rsp_data_r;
    logic                  rsp_dirty_r;
    logic [WAY_W-1:0]      rsp_victim_way_r;
    logic [TAG_BITS-1:0]   rsp_victim_tag_r;
    logic                  rsp_victim_dirty_r;
    logic                  rsp_perr_r;

    // ---------------------------------------------------------- comb signals
    logic                  accept_s;
    logic [NUM_WAYS-1:0]   set_valid_s;
    logic [NUM_WAYS-1:0]   set_dirty_s;
    logic [PLRU_W-1:0]     set_plru_s;
    logic [NUM_WAYS-1:0]   match_s;
    logic                  lookup_hit_s;
    logic [WAY_W-1:0]      hit_way_s;
    logic [WAY_W-1:0]      inv_way_s;
    logic [WAY_W-1:0]      victim_way_s;
    logic [WAY_W-1:0]      sel_way_s;
    logic                  sel_valid_s;
    logic [DATA_WIDTH-1:0] sel_data_s;
    logic [DATA_WIDTH-1:0] tgt_data_s;
    logic [DATA_WIDTH-1:0] merged_s;
    logic                  perr_s;
    logic                  rsp_hit_s;
    logic [NUM_WAYS-1:0]   valid_nxt_s;
    logic [NUM_WAYS-1:0]   dirty_nxt_s;
    logic [PLRU_W-1:0]     plru_nxt_s;
    logic                  wr_line_s;
    logic                  wr_tag_s;
    logic [DATA_WIDTH-1:0] line_nxt_s;

    assign accept_s = req_valid_i & ready_r;

    // Set read-out, tag compare, victim pick and parity check for the request.
    always_comb begin
        set_valid_s = valid_r[req_set_i];
        set_dirty_s = dirty_r[req_set_i];
        set_plru_s  = plru_r[req_set_i];
        match_s     = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            match_s[w] = set_valid_s[w] && (tag_r[req_set_i][w] == req_tag_i);
        end
        lookup_hit_s = |match_s;
        // Descending scans leave the lowest matching / invalid index selected.
        hit_way_s = '0;
        inv_way_s = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            hit_way_s = match_s[w]      ? WAY_W'(w) : hit_way_s;
            inv_way_s = !set_valid_s[w] ? WAY_W'(w) : inv_way_s;
        end
        victim_way_s = (&set_valid_s) ? plru_victim(set_plru_s) : inv_way_s;
        sel_way_s    = (req_op_i == OP_LOOKUP) ? hit_way_s : req_way_i;
        sel_valid_s  = (req_op_i == OP_LOOKUP) ? lookup_hit_s : set_valid_s[req_way_i];
        sel_data_s   = data_r[req_set_i][sel_way_s];
        tgt_data_s   = data_r[req_set_i][req_way_i];
`ifdef CACHE_WAY_ARRAY_PARITY_EN
        perr_s = sel_valid_s &&
                 ((byte_parity(sel_data_s) != dpar_r[req_set_i][sel_way_s]) ||
                  (tag_parity(tag_r[req_set_i][sel_way_s]) != tpar_r[req_set_i][sel_way_s]));
`else
        perr_s = 1'b0;
`endif
        case (req_op_i)
            OP_LOOKUP: rsp_hit_s = lookup_hit_s & ~perr_s;
            OP_WRITE:  rsp_hit_s = sel_valid_s;
            OP_INVAL:  rsp_hit_s = sel_valid_s;
            default:   rsp_hit_s = 1'b0;
        endcase
    end

    // Next contents of the addressed set for an accepted request.
    always_comb begin
        valid_nxt_s = set_valid_s;
        dirty_nxt_s = set_dirty_s;
        plru_nxt_s  = set_plru_s;
        wr_line_s   = 1'b0;
        wr_tag_s    = 1'b0;
        for (int b = 0; b < BE_W; b++) begin
            merged_s[b*8 +: 8] = req_be_i[b] ? req_data_i[b*8 +: 8] : tgt_data_s[b*8 +: 8];
        end
        line_nxt_s = req_data_i;
        case (req_op_i)
            OP_LOOKUP: begin
                if (lookup_hit_s && !perr_s) begin
                    plru_nxt_s = plru_touch(set_plru_s, hit_way_s);
                end else begin
                    plru_nxt_s = set_plru_s;
                end
            end
            OP_WRITE: begin
                if (set_valid_s[req_way_i]) begin
                    dirty_nxt_s[req_way_i] = 1'b1;
                    plru_nxt_s             = plru_touch(set_plru_s, req_way_i);
                    wr_line_s              = 1'b1;
                    line_nxt_s             = merged_s;
                end else begin
                    wr_line_s = 1'b0;
                end
            end
            OP_FILL: begin
                valid_nxt_s[req_way_i] = 1'b1;
                dirty_nxt_s[req_way_i] = req_dirty_i;
                plru_nxt_s             = plru_touch(set_plru_s, req_way_i);
                wr_line_s              = 1'b1;
                wr_tag_s               = 1'b1;
            end
            OP_INVAL: begin
                valid_nxt_s[req_way_i] = 1'b0;
                dirty_nxt_s[req_way_i] = 1'b0;
            end
            default: begin
                wr_line_s = 1'b0;
            end
        endcase
    end

`ifdef CACHE_WAY_ARRAY_PARITY_EN
    // Parity for the line being written: refresh only bytes actually written
    // so an existing error in untouched bytes stays detectable.
    always_comb begin
        dpar_nxt_s = dpar_r[req_set_i][req_way_i];
        for (int b = 0; b < BE_W; b++) begin
            if ((req_op_i == OP_FILL) || req_be_i[b]) begin
                dpar_nxt_s[b] = ^req_data_i[b*8 +: 8];
            end else begin
                dpar_nxt_s[b] = dpar_r[req_set_i][req_way_i][b];
            end
        end
    end
`endif

    // Flush sequencer: one set per cycle, then a single done cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r     <= ST_IDLE;
            flush_set_r <= '0;
            ready_r     <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (flush_i) begin
                        state_r     <= ST_WALK;
                        flush_set_r <= '0;
                        ready_r     <= 1'b0;
                        busy_r      <= 1'b1;
                    end
                    done_r <= 1'b0;
                end
                ST_WALK: begin
                    if (flush_set_r == SET_W'(NUM_SETS - 1)) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end else begin
                        flush_set_r <= flush_set_r + SET_W'(1);
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    // Valid/dirty/PLRU: cleared by reset or flush walk, else updated by requests.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_r[s] <= '0;
                dirty_r[s] <= '0;
                plru_r[s]  <= '0;
            end
        end else if (state_r == ST_WALK) begin
            valid_r[flush_set_r] <= '0;
            dirty_r[flush_set_r] <= '0;
            plru_r[flush_set_r]  <= '0;
        end else if (accept_s) begin
            valid_r[req_set_i] <= valid_nxt_s;
            dirty_r[req_set_i] <= dirty_nxt_s;
            plru_r[req_set_i]  <= plru_nxt_s;
        end
    end

    // Line payload storage; unreset since it is only visible behind a valid bit.
    always_ff @(posedge clk_i) begin
        if (accept_s && wr_line_s) begin
            data_r[req_set_i][req_way_i] <= line_nxt_s;
`ifdef CACHE_WAY_ARRAY_PARITY_EN
            dpar_r[req_set_i][req_way_i] <= dpar_nxt_s;
`endif
        end
        if (accept_s && wr_tag_s) begin
            tag_r[req_set_i][req_way_i] <= req_tag_i;
`ifdef CACHE_WAY_ARRAY_PARITY_EN
            tpar_r[req_set_i][req_way_i] <= tag_parity(req_tag_i);
`endif
        end
    end

    // Response register: captures pre-update view of the set on acceptance.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rsp_valid_r        <= 1'b0;
            rsp_hit_r          <= 1'b0;
            rsp_way_r          <= '0;
            rsp_data_r         <= '0;
            rsp_dirty_r        <= 1'b0;
            rsp_victim_way_r   <= '0;
            rsp_victim_tag_r   <= '0;
            rsp_victim_dirty_r <= 1'b0;
            rsp_perr_r         <= 1'b0;
        end else begin
            rsp_valid_r <= accept_s;
            if (accept_s) begin
                rsp_hit_r          <= rsp_hit_s;
                rsp_way_r          <= sel_way_s;
                rsp_data_r         <= sel_valid_s ? sel_data_s : '0;
                rsp_dirty_r        <= sel_valid_s & set_dirty_s[sel_way_s];
                rsp_victim_way_r   <= victim_way_s;
                rsp_victim_tag_r   <= set_valid_s[victim_way_s] ?
                                      tag_r[req_set_i][victim_way_s] : '0;
                rsp_victim_dirty_r <= set_valid_s[victim_way_s] & set_dirty_s[victim_way_s];
                rsp_perr_r         <= perr_s;
            end
        end
    end

    assign req_ready_o        = ready_r;
    assign flush_busy_o       = busy_r;
    assign flush_done_o       = done_r;
    assign rsp_valid_o        = rsp_valid_r;
    assign rsp_hit_o          = rsp_hit_r;
    assign rsp_way_o          = rsp_way_r;
    assign rsp_data_o         = rsp_data_r;
    assign rsp_dirty_o        = rsp_dirty_r;
    assign rsp_victim_way_o   = rsp_victim_way_r;
    assign rsp_victim_tag_o   = rsp_victim_tag_r;
    assign rsp_victim_dirty_o = rsp_victim_dirty_r;
    assign rsp_perr_o         = rsp_perr_r;

endmodule
